// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS fetch path: PC source
// encodings, instruction register field positions and the fetch FSM states.
package mips_pkg;

   localparam logic [1:0] PCSRC_INC = 2'b00;
   localparam logic [1:0] PCSRC_BR  = 2'b01;
   localparam logic [1:0] PCSRC_JMP = 2'b10;

   localparam int OP_HI    = 15;
   localparam int OP_LO    = 12;
   localparam int RS_HI    = 11;
   localparam int RS_LO    = 8;
   localparam int RT_HI    = 7;
   localparam int RT_LO    = 4;
   localparam int RD_HI    = 3;
   localparam int RD_LO    = 0;
   localparam int FUNCF_HI = 3;
   localparam int FUNCF_LO = 0;
   localparam int IMM_HI   = 7;
   localparam int IMM_LO   = 0;

   // Number of low PC bits replaced by the jump target field of IR.
   localparam int JMP_W    = 12;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/fetch_pc_unit_wdog.sv
// Wait-cycle counter for the instruction fetch. Counts cycles spent waiting
// for mem_ready and flags when the count has reached TIMEOUT.
module fetch_wdog #(
   parameter int CNT_W   = 4,
   parameter int TIMEOUT = 15
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic expired
);

   logic [CNT_W-1:0] cnt;

   // Clear has priority so a fresh fetch always starts counting from zero.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   assign expired = (cnt == CNT_W'(TIMEOUT));

endmodule

// File: rtl/fetch_pc_unit.sv
// Program counter, instruction register and instruction-fetch handshake
// for the multicycle MIPS core.
//
//   state | meaning
//   IDLE  | no fetch in flight; pc_en branch/jump updates accepted
//   REQ   | first request cycle, mem_req up, mem_addr = PC
//   WAIT  | memory stalled; request held until ready or timeout
module fetch_pc_unit
   import mips_pkg::*;
#(
   parameter int          DATA_W   = 16,
   parameter int          ADDR_W   = 16,
   parameter int unsigned RESET_PC = 0,
   parameter int          TIMEOUT  = 15
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              IRwrite,
   input  logic              Memread,
   input  logic              IorD,
   input  logic [1:0]        PCsrc,
   input  logic              pc_en,
   input  logic              zero,
   input  logic [ADDR_W-1:0] alu_out,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [ADDR_W-1:0] pc,
   output logic [3:0]        OP,
   output logic [3:0]        rs,
   output logic [3:0]        rt,
   output logic [3:0]        rd,
   output logic [3:0]        funcf,
   output logic [7:0]        imm,
   output logic              stall,
   output logic              fetch_done,
   output logic              fetch_err
);

   fetch_state_t      state;
   logic [DATA_W-1:0] ir;
   logic              fetch_start;
   logic              busy;
   logic              wd_clr;
   logic              wd_en;
   logic              wd_expired;

   assign fetch_start = IRwrite & Memread & ~IorD;
   assign busy        = (state != IDLE);

   // Counter runs only while a request is outstanding and unanswered.
   assign wd_clr = ~busy | mem_ready | wd_expired;
   assign wd_en  = busy & ~mem_ready & ~wd_expired;

   fetch_wdog #(
      .CNT_W   (4),
      .TIMEOUT (TIMEOUT)
   ) u_wdog (
      .clk     (clk),
      .reset   (reset),
      .clr     (wd_clr),
      .en      (wd_en),
      .expired (wd_expired)
   );

   // Fetch FSM with registered handshake outputs and PC/IR updates.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         pc         <= ADDR_W'(RESET_PC);
         ir         <= '0;
         mem_req    <= 1'b0;
         mem_addr   <= '0;
         fetch_done <= 1'b0;
         fetch_err  <= 1'b0;
      end else begin
         fetch_done <= 1'b0;
         case (state)
            IDLE: begin
               if (fetch_start) begin
                  state    <= REQ;
                  mem_req  <= 1'b1;
                  mem_addr <= pc;
               end else if (pc_en) begin
                  case (PCsrc)
                     PCSRC_BR:  if (zero) pc <= alu_out;
                     PCSRC_JMP: pc <= {pc[ADDR_W-1:JMP_W], ir[JMP_W-1:0]};
                     default:   ;
                  endcase
               end
            end
            REQ, WAIT: begin
               if (mem_ready) begin
                  ir         <= mem_rdata;
                  pc         <= pc + ADDR_W'(1);
                  mem_req    <= 1'b0;
                  fetch_done <= 1'b1;
                  state      <= IDLE;
               end else if (wd_expired) begin
                  // Abort leaves PC and IR untouched; only the sticky flag records it.
                  fetch_err <= 1'b1;
                  mem_req   <= 1'b0;
                  state     <= IDLE;
               end else begin
                  state <= WAIT;
               end
            end
            default: begin
               state   <= IDLE;
               mem_req <= 1'b0;
            end
         endcase
      end
   end

   assign stall = busy;

   assign OP    = ir[OP_HI:OP_LO];
   assign rs    = ir[RS_HI:RS_LO];
   assign rt    = ir[RT_HI:RT_LO];
   assign rd    = ir[RD_HI:RD_LO];
   assign funcf = ir[FUNCF_HI:FUNCF_LO];
   assign imm   = ir[IMM_HI:IMM_LO];

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Scoreboard bench for fetch_pc_unit: the driver pushes the expected outcome
// of every fetch; a negedge monitor pops it when the request completes.
module tb_fetch_pc_unit;

   localparam int TMO = 15;

   logic        clk = 1'b0;
   logic        reset;
   logic        IRwrite, Memread, IorD, pc_en, zero, mem_ready;
   logic [1:0]  PCsrc;
   logic [15:0] alu_out, mem_rdata;
   logic        mem_req, stall, fetch_done, fetch_err;
   logic [15:0] mem_addr, pc;
   logic [3:0]  OP, rs, rt, rd, funcf;
   logic [7:0]  imm;

   fetch_pc_unit #(
      .DATA_W(16), .ADDR_W(16), .RESET_PC(0), .TIMEOUT(TMO)
   ) dut (
      .clk(clk), .reset(reset), .IRwrite(IRwrite), .Memread(Memread),
      .IorD(IorD), .PCsrc(PCsrc), .pc_en(pc_en), .zero(zero),
      .alu_out(alu_out), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .mem_req(mem_req), .mem_addr(mem_addr), .pc(pc), .OP(OP), .rs(rs),
      .rt(rt), .rd(rd), .funcf(funcf), .imm(imm), .stall(stall),
      .fetch_done(fetch_done), .fetch_err(fetch_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] addr;
      logic [15:0] pc;
      logic [15:0] ir;
      bit          timeout;
      bit          err;
      int          cycles;
   } exp_t;

   exp_t        q[$];
   exp_t        e;
   int          errors = 0;
   int          checks = 0;
   logic [15:0] m_pc, m_ir;
   bit          m_err;
   bit          mon_on = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: count request/stall cycles, check address, score completions.
   int req_cnt = 0;
   int stall_cnt = 0;
   bit prev_req = 1'b0;
   always @(negedge clk) begin
      if (!reset || !mon_on) begin
         prev_req  = 1'b0;
         req_cnt   = 0;
         stall_cnt = 0;
      end else if (mem_req) begin
         req_cnt++;
         if (stall) stall_cnt++;
         if (q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_req: mem_req high with no fetch issued at %0t", $time);
         end else begin
            chk("mem_addr", 32'(mem_addr), 32'(q[0].addr));
         end
         prev_req = 1'b1;
      end else if (prev_req) begin
         if (q.size() == 0) begin
            checks++; errors++;
            $display("FAIL orphan_completion: no expected entry at %0t", $time);
         end else begin
            e = q.pop_front();
            chk("req_cycles",  32'(req_cnt),   32'(e.cycles));
            chk("stall_cycles", 32'(stall_cnt), 32'(e.cycles));
            chk("pc",          32'(pc),        32'(e.pc));
            chk("ir",          32'({OP, rs, rt, rd}), 32'(e.ir));
            chk("imm",         32'(imm),       32'(e.ir[7:0]));
            chk("funcf",       32'(funcf),     32'(e.ir[3:0]));
            chk("fetch_done",  32'(fetch_done), 32'(!e.timeout));
            chk("fetch_err",   32'(fetch_err), 32'(e.err));
         end
         prev_req  = 1'b0;
         req_cnt   = 0;
         stall_cnt = 0;
      end else begin
         chk("done_idle",  32'(fetch_done), 32'(0));
         chk("stall_idle", 32'(stall), 32'(0));
      end
   end

   task automatic clear_inputs();
      IRwrite = 0; Memread = 0; IorD = 0; pc_en = 0; PCsrc = 0; zero = 0;
      alu_out = 0; mem_ready = 0; mem_rdata = 0;
   endtask

   // w = request cycle (0 = first) on which mem_ready is given; w > TMO never.
   task automatic do_fetch(input int w, input logic [15:0] data, input bit with_pcen);
      exp_t x;
      int   last;
      @(negedge clk);
      IRwrite = 1; Memread = 1; IorD = 0;
      if (with_pcen) begin
         pc_en = 1; PCsrc = 2'b01; zero = 1; alu_out = 16'h1234;
      end
      x.addr = m_pc;
      if (w <= TMO) begin
         m_ir = data; m_pc = m_pc + 16'd1;
         x.timeout = 0; x.cycles = w + 1; last = w;
      end else begin
         m_err = 1;
         x.timeout = 1; x.cycles = TMO + 1; last = TMO;
      end
      x.pc = m_pc; x.ir = m_ir; x.err = m_err;
      q.push_back(x);
      for (int i = 0; i <= last; i++) begin
         @(negedge clk);
         IRwrite   = 1'($urandom_range(0, 1));
         Memread   = 1'($urandom_range(0, 1));
         IorD      = 1'($urandom_range(0, 1));
         pc_en     = 1'($urandom_range(0, 1));
         PCsrc     = 2'($urandom_range(0, 3));
         zero      = 1'b1;
         alu_out   = 16'($urandom);
         mem_rdata = (i == w) ? data : 16'($urandom);
         mem_ready = (i == w);
      end
      @(negedge clk);
      clear_inputs();
   endtask

   task automatic do_pcen(input logic [1:0] src, input bit z, input logic [15:0] tgt);
      @(negedge clk);
      pc_en = 1; PCsrc = src; zero = z; alu_out = tgt;
      if (src == 2'b01 && z) m_pc = tgt;
      else if (src == 2'b10) m_pc = {m_pc[15:12], m_ir[11:0]};
      @(negedge clk);
      clear_inputs();
      chk("pc_after_pcen", 32'(pc), 32'(m_pc));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      reset = 1'b0;
      clear_inputs();
      m_pc = 16'h0000; m_ir = 16'h0000; m_err = 0;
      repeat (3) @(negedge clk);
      chk("rst_pc",    32'(pc), 32'(0));
      chk("rst_ir",    32'({OP, rs, rt, rd}), 32'(0));
      chk("rst_req",   32'(mem_req), 32'(0));
      chk("rst_stall", 32'(stall), 32'(0));
      chk("rst_done",  32'(fetch_done), 32'(0));
      chk("rst_err",   32'(fetch_err), 32'(0));
      reset = 1'b1;
      mon_on = 1'b1;

      do_fetch(0, 16'h8123, 0);
      chk("op_8123",    32'(OP), 32'(4'b1000));
      chk("funcf_8123", 32'(funcf), 32'(4'h3));
      chk("pc_after_first", 32'(pc), 32'(1));

      do_fetch(3, 16'h4A5C, 0);
      do_fetch(TMO + 1, 16'hDEAD, 0);
      do_fetch(0, 16'h1357, 0);

      do_pcen(2'b01, 1, 16'h0040);
      do_pcen(2'b01, 0, 16'h0999);
      do_pcen(2'b01, 1, 16'h1004);
      do_fetch(1, 16'h3ABC, 0);
      do_pcen(2'b10, 0, 16'h0000);
      chk("jump_pc", 32'(pc), 32'(16'h1ABC));
      do_pcen(2'b11, 1, 16'h7777);
      do_pcen(2'b00, 1, 16'h7777);

      do_pcen(2'b01, 1, 16'hFFFF);
      do_fetch(0, 16'h2468, 0);
      chk("pc_wrap", 32'(pc), 32'(0));
      do_fetch(2, 16'h9ABC, 1);

      for (int n = 0; n < 25; n++) begin
         if ($urandom_range(0, 2) == 0)
            do_pcen(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 16'($urandom));
         else if ($urandom_range(0, 5) == 0)
            do_fetch(TMO + 1, 16'($urandom), 1'($urandom_range(0, 1)));
         else
            do_fetch($urandom_range(0, TMO), 16'($urandom), 1'($urandom_range(0, 1)));
      end

      // Asynchronous reset in the middle of a stalled fetch.
      @(negedge clk);
      mon_on = 1'b0;
      IRwrite = 1; Memread = 1; IorD = 0;
      @(negedge clk);
      clear_inputs();
      repeat (3) @(negedge clk);
      chk("pre_rst_req", 32'(mem_req), 32'(1));
      #2 reset = 1'b0;
      #1;
      chk("arst_req",   32'(mem_req), 32'(0));
      chk("arst_pc",    32'(pc), 32'(0));
      chk("arst_ir",    32'({OP, rs, rt, rd}), 32'(0));
      chk("arst_err",   32'(fetch_err), 32'(0));
      chk("arst_stall", 32'(stall), 32'(0));
      q.delete();
      m_pc = 16'h0000; m_ir = 16'h0000; m_err = 0;
      @(negedge clk);
      reset = 1'b1;
      mon_on = 1'b1;
      do_fetch(1, 16'h5A5A, 0);
      repeat (2) @(negedge clk);
      chk("queue_empty", 32'(q.size()), 32'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fetch_pc_unit.md
# fetch_pc_unit

Owns the program counter and instruction register of the multicycle MIPS core. It performs the instruction-memory fetch handshake when the control FSM requests it, then presents the decoded IR fields (OP, funcf, register indices, immediate) back to the control FSM and datapath. It also applies branch and jump PC updates selected by the control FSM's PCsrc. It sits directly upstream of the control FSM: it produces the OP/funcf that FSM consumes and absorbs its Fetch-state strobes.

## Interface
- DATA_W, 16, instruction/data word width
- ADDR_W, 16, word address width (PC is word-addressed)
- RESET_PC, 0, PC value after reset
- TIMEOUT, 15, maximum wait cycles for mem_ready before abort (4-bit counter)
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- IRwrite, Memread, IorD  in  1 each  control strobes; fetch_start = IRwrite & Memread & ~IorD
- PCsrc  in  2  00 increment (fetch only), 01 branch, 10 jump, 11 reserved
- pc_en  in  1  one-cycle strobe applying branch/jump selected by PCsrc
- zero  in  1  ALU zero flag, qualifies branch
- alu_out  in  ADDR_W  registered ALU result (branch target)
- mem_rdata  in  DATA_W  instruction memory read data
- mem_ready  in  1  memory read data valid this cycle
- mem_req  out  1  read request, held until accepted
- mem_addr  out  ADDR_W  equals PC while mem_req high
- pc  out  ADDR_W  current PC
- OP  out  4  IR[15:12];  rs, rt, rd  out  4 each  IR[11:8], IR[7:4], IR[3:0];  funcf  out  4  IR[3:0];  imm  out  8  IR[7:0]
- stall  out  1  high whenever FSM is not IDLE
- fetch_done  out  1  one-cycle pulse after IR loaded
- fetch_err  out  1  sticky timeout flag

## Operation
- FSM states: IDLE, REQ, WAIT.
- IDLE: on fetch_start -> REQ. On pc_en (and no fetch_start): PCsrc 01 with zero=1 -> PC <= alu_out; 01 with zero=0 -> PC unchanged; 10 -> PC <= {PC[15:12], IR[11:0]}; 00/11 -> PC unchanged.
- fetch_start and pc_en in the same IDLE cycle: fetch wins, pc_en dropped.
- REQ: mem_req=1, mem_addr=PC; if mem_ready -> load IR, PC <= PC+1, -> IDLE; else -> WAIT, wait counter = 1.
- WAIT: mem_req stays 1, mem_addr stable; mem_ready -> same load as REQ, -> IDLE; counter reaching TIMEOUT without ready -> fetch_err <= 1, IR and PC unchanged, -> IDLE.
- fetch_start and pc_en while not IDLE are ignored.
- PC+1 wraps modulo 2^ADDR_W (0xFFFF -> 0x0000); no flag.
- fetch_err cleared only by reset; fetches continue after it is set.

## Timing
- Reset values: state IDLE, PC=RESET_PC, IR=0 (so OP=0, all fields 0), mem_req=0, stall=0, fetch_done=0, fetch_err=0, counter=0. Asynchronous assertion mid-fetch aborts immediately; mem_req drops without waiting for a clock.
- fetch_start sampled at edge N -> mem_req high from N+1.
- mem_ready high at the same edge -> IR/PC updated at that edge; fetch_done high for the following cycle; stall low from that cycle.
- Zero-wait fetch: 1 stall cycle. Each extra wait cycle adds 1.
- Timeout: mem_req falls and fetch_err rises at the edge on which the counter reaches TIMEOUT, i.e. TIMEOUT+1 cycles after mem_req rose; fetch_done is not pulsed.
- pc_en update is visible on pc one cycle after the strobe edge.
- All outputs are registered except the IR field slices (wired from IR) and stall (decoded from state).

## Structure
- Shared package mips_pkg: PCsrc encodings (PCSRC_INC, PCSRC_BR, PCSRC_JMP), IR field bit positions, fetch state enum (IDLE/REQ/WAIT).
- One natural sub-module: fetch_wdog (wait counter plus TIMEOUT compare, with clear/enable inputs). PC/IR registers and the FSM stay in the top.

## Test plan
- Reset, then fetch_start with mem_ready on the first REQ cycle, mem_rdata=0x8123 -> IR=0x8123, OP=4'b1000, funcf=4'h3, PC 0->1, fetch_done one cycle, stall exactly 1 cycle.
- 3 wait cycles before mem_ready -> mem_addr held at PC for all 4 request cycles, stall 4 cycles, IR loaded once.
- mem_ready never asserted, TIMEOUT=15 -> mem_req high 16 cycles, fetch_err=1, PC/IR unchanged, next fetch works normally.
- Branch: pc_en, PCsrc=01, zero=1, alu_out=0x0040 -> PC=0x0040; repeat with zero=0 -> PC unchanged. Jump: IR=0x3ABC, PC=0x1005, PCsrc=10 -> PC=0x1ABC.
- PC=0xFFFF fetch -> PC=0x0000; fetch_start with pc_en in the same cycle -> fetch occurs, branch ignored.
- reset asserted in WAIT -> mem_req low immediately, PC=RESET_PC, IR=0, fetch_err=0.
